// File: rtl/mux4_sequencer.sv
// Serializes a 4-bit word onto a downstream 4->1 mux by stepping its select,
// holding each slot for HOLD_CYCLES clocks; supports back-to-back frames and flush.
module mux4_sequencer #(
   parameter int HOLD_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [3:0] in_data,
   input  logic       flush,
   output logic       in_ready,
   output logic       d0,
   output logic       d1,
   output logic       d2,
   output logic       d3,
   output logic [1:0] sel,
   output logic       out_valid,
   output logic       last
);

   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] hold_cnt;
   logic             hold_done;
   logic             accept;

   assign hold_done = (hold_cnt == HOLD_MAX);
   assign last      = (state == SHIFT) && (sel == 2'd3) && hold_done;
   assign in_ready  = (state == IDLE) || last;
   assign accept    = in_valid && in_ready && !flush;
   assign out_valid = (state == SHIFT);

   // Flush outranks accept; the data bits are only ever written by an accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         sel      <= 2'd0;
         hold_cnt <= '0;
         d0       <= 1'b0;
         d1       <= 1'b0;
         d2       <= 1'b0;
         d3       <= 1'b0;
      end else if (flush) begin
         state    <= IDLE;
         sel      <= 2'd0;
         hold_cnt <= '0;
      end else if (accept) begin
         state    <= SHIFT;
         sel      <= 2'd0;
         hold_cnt <= '0;
         d0       <= in_data[0];
         d1       <= in_data[1];
         d2       <= in_data[2];
         d3       <= in_data[3];
      end else if (state == SHIFT) begin
         if (hold_done) begin
            hold_cnt <= '0;
            // sel wraps 3 -> 0 on the final slot, which is also where the frame ends
            sel      <= sel + 2'd1;
            if (last) begin
               state <= IDLE;
            end
         end else begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mux4_sequencer.sv
// Bench for mux4_sequencer: two instances (HOLD_CYCLES 1 and 3) each feeding a
// delayed 4->1 mux, checked by a per-cycle scoreboard against a frame-level model.
module tb_mux4_sequencer;

   typedef struct packed {
      logic [1:0] sel;
      logic       bit_v;
      logic       last;
      logic [3:0] word;
   } exp_t;

   logic       clk;
   logic       rst       [2];
   logic       in_valid  [2];
   logic [3:0] in_data   [2];
   logic       flush     [2];
   logic       in_ready  [2];
   logic       d0        [2];
   logic       d1        [2];
   logic       d2        [2];
   logic       d3        [2];
   logic [1:0] sel       [2];
   logic       out_valid [2];
   logic       last      [2];
   logic       mux_y0;
   logic       mux_y1;

   exp_t       sbq      [2][$];
   logic [3:0] held     [2];
   logic       cur_idle [2];
   logic       cur_last [2];
   logic [1:0] cur_sel  [2];
   int         n_pass;
   int         n_total;
   exp_t       mon_e;
   logic       mon_y;
   logic [3:0] mon_d;

   mux4_sequencer #(.HOLD_CYCLES(1)) u_h1 (
      .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
      .flush(flush[0]), .in_ready(in_ready[0]), .d0(d0[0]), .d1(d1[0]), .d2(d2[0]),
      .d3(d3[0]), .sel(sel[0]), .out_valid(out_valid[0]), .last(last[0])
   );

   mux4_sequencer #(.HOLD_CYCLES(3)) u_h3 (
      .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
      .flush(flush[1]), .in_ready(in_ready[1]), .d0(d0[1]), .d1(d1[1]), .d2(d2[1]),
      .d3(d3[1]), .sel(sel[1]), .out_valid(out_valid[1]), .last(last[1])
   );

   // Downstream NAND-built mux: decode plus two NAND levels at 10 each.
   assign #30 mux_y0 = sel[0][1] ? (sel[0][0] ? d3[0] : d2[0]) : (sel[0][0] ? d1[0] : d0[0]);
   assign #30 mux_y1 = sel[1][1] ? (sel[1][0] ? d3[1] : d2[1]) : (sel[1][0] ? d1[1] : d0[1]);

   initial clk = 1'b0;
   always #50 clk = ~clk;

   function automatic void chk(input string nm, input int k, input logic [3:0] act,
                               input logic [3:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL u%0d %s: got %0h expected %0h at %0t", k, nm, act, exp, $time);
   endfunction

   function automatic int hold_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   // A frame is four slots, slot s carrying word[s] for hold_of(k) cycles.
   function automatic void push_frame(input int k, input logic [3:0] w);
      exp_t e;
      for (int s = 0; s < 4; s++) begin
         for (int h = 0; h < hold_of(k); h++) begin
            e.sel   = 2'(s);
            e.bit_v = w[s];
            e.last  = (s == 3) && (h == hold_of(k) - 1);
            e.word  = w;
            sbq[k].push_back(e);
         end
      end
   endfunction

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         mon_y = (k == 0) ? mux_y0 : mux_y1;
         mon_d = {d3[k], d2[k], d1[k], d0[k]};
         if (sbq[k].size() > 0) begin
            mon_e = sbq[k].pop_front();
            chk("out_valid", k, {3'b0, out_valid[k]}, 4'd1);
            chk("sel", k, {2'b0, sel[k]}, {2'b0, mon_e.sel});
            chk("mux_y", k, {3'b0, mon_y}, {3'b0, mon_e.bit_v});
            chk("last", k, {3'b0, last[k]}, {3'b0, mon_e.last});
            chk("data", k, mon_d, mon_e.word);
            chk("in_ready", k, {3'b0, in_ready[k]}, {3'b0, mon_e.last});
            held[k]     = mon_e.word;
            cur_idle[k] = 1'b0;
            cur_last[k] = mon_e.last;
            cur_sel[k]  = mon_e.sel;
         end else begin
            chk("idle_out_valid", k, {3'b0, out_valid[k]}, 4'd0);
            chk("idle_sel", k, {2'b0, sel[k]}, 4'd0);
            chk("idle_last", k, {3'b0, last[k]}, 4'd0);
            chk("idle_data", k, mon_d, held[k]);
            chk("idle_in_ready", k, {3'b0, in_ready[k]}, 4'd1);
            cur_idle[k] = 1'b1;
            cur_last[k] = 1'b0;
            cur_sel[k]  = 2'd0;
         end
      end
   end

   // Called just after a falling edge: inputs take effect at the next rising edge.
   task automatic cycle(input int k, input logic v, input logic [3:0] w, input logic f);
      logic rdy;
      rdy         = cur_idle[k] || cur_last[k];
      in_valid[k] = v;
      in_data[k]  = w;
      flush[k]    = f;
      if (f) sbq[k].delete();
      else if (v && rdy) push_frame(k, w);
      @(negedge clk);
      #1;
   endtask

   task automatic check_reset_values(input int k);
      chk("rst_out_valid", k, {3'b0, out_valid[k]}, 4'd0);
      chk("rst_sel", k, {2'b0, sel[k]}, 4'd0);
      chk("rst_last", k, {3'b0, last[k]}, 4'd0);
      chk("rst_data", k, {d3[k], d2[k], d1[k], d0[k]}, 4'd0);
      chk("rst_in_ready", k, {3'b0, in_ready[k]}, 4'd1);
   endtask

   task automatic async_reset(input int k);
      in_valid[k] = 1'b0;
      flush[k]    = 1'b0;
      #10;
      rst[k] = 1'b1;
      sbq[k].delete();
      held[k] = 4'h0;
      #10;
      check_reset_values(k);
      #10;
      rst[k] = 1'b0;
      @(negedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int k, input int n);
      for (int i = 0; i < n; i++) cycle(k, 1'b0, 4'h0, 1'b0);
   endtask

   initial begin
      int i;
      n_pass  = 0;
      n_total = 0;
      for (int k = 0; k < 2; k++) begin
         rst[k]      = 1'b1;
         in_valid[k] = 1'b0;
         in_data[k]  = 4'h0;
         flush[k]    = 1'b0;
         held[k]     = 4'h0;
         cur_idle[k] = 1'b1;
         cur_last[k] = 1'b0;
         cur_sel[k]  = 2'd0;
      end
      #10;
      check_reset_values(0);
      check_reset_values(1);
      #20;
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      @(negedge clk);
      #1;

      // Single word, one cycle per slot
      cycle(0, 1'b1, 4'b1010, 1'b0);
      idle_cycles(0, 6);

      // Two words back to back with in_valid held through the first frame
      cycle(1, 1'b1, 4'b0110, 1'b0);
      for (int j = 0; j < 12; j++) cycle(1, 1'b1, 4'b1001, 1'b0);
      idle_cycles(1, 14);

      // Flush at slot 2 with a word waiting
      cycle(1, 1'b1, 4'b1100, 1'b0);
      for (i = 0; i < 20 && !(cur_sel[1] == 2'd2 && !cur_idle[1]); i++)
         cycle(1, 1'b1, 4'b0011, 1'b0);
      chk("reach_slot2", 1, {3'b0, (i < 20)}, 4'd1);
      cycle(1, 1'b1, 4'b0011, 1'b1);
      idle_cycles(1, 4);

      // Asynchronous reset in slot 1, then a fresh frame
      cycle(1, 1'b1, 4'b0101, 1'b0);
      for (i = 0; i < 20 && !(cur_sel[1] == 2'd1 && !cur_idle[1]); i++)
         cycle(1, 1'b0, 4'h0, 1'b0);
      chk("reach_slot1", 1, {3'b0, (i < 20)}, 4'd1);
      async_reset(1);
      cycle(1, 1'b1, 4'b1111, 1'b0);
      idle_cycles(1, 14);

      // Randomized traffic on each instance
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 300; j++) begin
            if ($urandom_range(0, 99) < 2) async_reset(k);
            else cycle(k, ($urandom_range(0, 3) != 0), 4'($urandom),
                       ($urandom_range(0, 19) == 0));
         end
         idle_cycles(k, 14);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mux4_sequencer.md
MUX4_SEQUENCER -- requirements
Module: mux4_sequencer

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 1, giving the number of clock cycles each select value is held (legal range 1..16).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning a 4-bit word is offered on in_data.
REQ-005 The block SHALL have port in_data, input, 4 bits, the word to be serialized (bit i goes to slot i).
REQ-006 The block SHALL have port flush, input, 1 bit, a synchronous abort of the current frame.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning a word offered now will be accepted this edge.
REQ-008 The block SHALL have ports d0, d1, d2, d3, output, 1 bit each, the held data bits driving the downstream 4->1 mux data inputs.
REQ-009 The block SHALL have port sel, output, 2 bits, driving the downstream 4->1 mux select.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning the downstream mux output is a valid serial bit this cycle.
REQ-011 The block SHALL have port last, output, 1 bit, marking the final cycle of slot 3 of a frame.

Function
REQ-012 The block SHALL implement two states: IDLE and SHIFT.
REQ-013 Accept SHALL occur on a rising edge where in_valid=1, in_ready=1 and flush=0.
REQ-014 in_ready SHALL be 1 in IDLE, and in SHIFT only when last=1; otherwise 0.
REQ-015 On accept, d3..d0 SHALL load in_data[3:0], sel SHALL become 0, the hold counter SHALL become 0, and the state SHALL become SHIFT.
REQ-016 d0..d3 SHALL change only on accept or reset, never during a frame.
REQ-017 In SHIFT, the hold counter SHALL increment each cycle from 0 to HOLD_CYCLES-1; at HOLD_CYCLES-1 it SHALL wrap to 0 and sel SHALL increment by 1.
REQ-018 last SHALL equal (state=SHIFT and sel=3 and hold counter=HOLD_CYCLES-1), combinationally.
REQ-019 On a last cycle with accept, the block SHALL reload per REQ-015 and stay in SHIFT, giving back-to-back frames with zero idle cycles.
REQ-020 On a last cycle without accept, the state SHALL become IDLE and sel SHALL return to 0.
REQ-021 out_valid SHALL be 1 exactly when state=SHIFT; a frame lasts exactly 4*HOLD_CYCLES cycles.
REQ-022 Latency: the first serial slot (sel=0, out_valid=1) SHALL appear in the cycle immediately after the accepting edge.
REQ-023 flush=1 at an edge SHALL force IDLE, sel=0, hold counter=0 and d0..d3 unchanged; flush SHALL have priority over accept, so no word is taken on that edge.
REQ-024 In IDLE, sel SHALL be 0, out_valid 0 and last 0.
REQ-025 With HOLD_CYCLES=1, sel SHALL advance every cycle and last SHALL be high for the single sel=3 cycle.

Reset
REQ-026 While rst=1, the block SHALL immediately (without a clock edge) drive state=IDLE, sel=0, hold counter=0, d0..d3=0, out_valid=0, last=0 and in_ready=1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release, the block SHALL be in IDLE, and the first accept SHALL start a fresh frame at sel=0.

Verification
REQ-028 With HOLD_CYCLES=1 and in_data=4'b1010 accepted once, the bench SHALL see sel 0,1,2,3 on consecutive cycles, serial d[sel] = 0,1,0,1, last only at sel=3, then out_valid=0.
REQ-029 With HOLD_CYCLES=3, 4'b0110 followed immediately by 4'b1001 (in_valid held), the bench SHALL see 24 consecutive out_valid cycles, each sel held 3 cycles, the second word loaded on the first frame's last cycle, and in_ready high only on last cycles.
REQ-030 With flush asserted at sel=2 while in_valid=1, the bench SHALL see IDLE next cycle, sel=0, d0..d3 unchanged and no word accepted on that edge.
REQ-031 With rst pulsed asynchronously (between edges) at sel=1, the bench SHALL see all outputs go to reset values before the next edge; an accept of 4'b1111 after release SHALL start at sel=0.
REQ-032 With in_valid=1 during mid-frame (non-last) cycles, the bench SHALL see in_ready=0 and d0..d3 stable until the last cycle.
REQ-033 Connecting d0..d3 and sel to the team 4->1 mux, the bench SHALL check that the mux output equals in_data[sel] once the mux has settled (nand_tpd=10) in every out_valid cycle.
